// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one L2 line port between the L1 I-cache and D-cache.
// Only the grant state and last-grant bit are registered; all L2/requester outputs are combinational.
module cache_arbiter (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_pmem_read,
  input  logic [15:0]  i_pmem_address,
  output logic [127:0] i_pmem_rdata,
  output logic         i_pmem_resp,
  input  logic         d_pmem_read,
  input  logic         d_pmem_write,
  input  logic [15:0]  d_pmem_address,
  input  logic [127:0] d_pmem_wdata,
  output logic [127:0] d_pmem_rdata,
  output logic         d_pmem_resp,
  output logic         l2_read,
  output logic         l2_write,
  output logic [15:0]  l2_address,
  output logic [127:0] l2_wdata,
  input  logic [127:0] l2_rdata,
  input  logic         l2_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t r_state;
  logic   r_last_grant;  // 0 = I-cache, 1 = D-cache

  logic w_i_req;
  logic w_d_req;
  logic w_unused;

  assign w_i_req  = i_pmem_read;
  assign w_d_req  = d_pmem_read | d_pmem_write;
  // Line-aligned addressing discards the byte offset.
  assign w_unused = ^{i_pmem_address[3:0], d_pmem_address[3:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_i_req && w_d_req) begin
            r_state      <= r_last_grant ? SERVE_I : SERVE_D;
            r_last_grant <= ~r_last_grant;
          end else if (w_i_req) begin
            r_state      <= SERVE_I;
            r_last_grant <= 1'b0;
          end else if (w_d_req) begin
            r_state      <= SERVE_D;
            r_last_grant <= 1'b1;
          end
        end
        SERVE_I, SERVE_D: begin
          if (l2_resp) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A simultaneous D read+write issues only the write.
  always_comb begin
    l2_read     = 1'b0;
    l2_write    = 1'b0;
    l2_address  = '0;
    l2_wdata    = '0;
    i_pmem_resp = 1'b0;
    d_pmem_resp = 1'b0;
    case (r_state)
      SERVE_I: begin
        l2_read     = 1'b1;
        l2_address  = {i_pmem_address[15:4], 4'h0};
        i_pmem_resp = l2_resp;
      end
      SERVE_D: begin
        l2_read     = d_pmem_read & ~d_pmem_write;
        l2_write    = d_pmem_write;
        l2_address  = {d_pmem_address[15:4], 4'h0};
        l2_wdata    = d_pmem_wdata;
        d_pmem_resp = l2_resp;
      end
      default: ;
    endcase
  end

  assign i_pmem_rdata = l2_rdata;
  assign d_pmem_rdata = l2_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed scenarios plus a randomized run checked against a transaction-level
// model of who currently owns the L2 port.
module tb_cache_arbiter;

  logic         clk;
  logic         reset;
  logic         i_pmem_read;
  logic [15:0]  i_pmem_address;
  logic [127:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [15:0]  d_pmem_address;
  logic [127:0] d_pmem_wdata;
  logic [127:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         l2_read;
  logic         l2_write;
  logic [15:0]  l2_address;
  logic [127:0] l2_wdata;
  logic [127:0] l2_rdata;
  logic         l2_resp;

  int n_checks = 0;
  int n_fail   = 0;

  wire [3:0] ctl = {l2_read, l2_write, i_pmem_resp, d_pmem_resp};

  cache_arbiter dut (
    .clk(clk), .reset(reset),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    i_pmem_read = 0; i_pmem_address = '0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
    l2_rdata = '0; l2_resp = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    cyc();
    cyc();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    i_pmem_read = 1; d_pmem_write = 1;
    d_pmem_address = 16'hFFFF; d_pmem_wdata = '1;
    cyc(); cyc();
    smp();
    n_checks++;
    if (ctl !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl, 4'b0000);
    end
    n_checks++;
    if (l2_address !== 16'h0 || l2_wdata !== 128'h0) begin
      n_fail++; $display("FAIL reset_l2_bus: got addr %h wdata %h expected zero", l2_address, l2_wdata);
    end
    cyc();
    reset = 0;
    clear_inputs();
  endtask

  task automatic test_i_read();
    logic [127:0] pat;
    pat = {16{8'hAA}};
    do_reset();
    i_pmem_read = 1; i_pmem_address = 16'h1234;
    for (int c = 0; c < 4; c++) begin
      l2_resp  = (c == 3);
      l2_rdata = (c == 3) ? pat : '0;
      smp();
      n_checks++;
      if (ctl !== {c >= 1, 1'b0, c == 3, 1'b0}) begin
        n_fail++; $display("FAIL i_read_ctl[%0d]: got %b expected %b", c, ctl, {c >= 1, 1'b0, c == 3, 1'b0});
      end
      if (c >= 1) begin
        n_checks++;
        if (l2_address !== 16'h1230) begin
          n_fail++; $display("FAIL i_read_addr[%0d]: got %h expected 1230", c, l2_address);
        end
      end
      if (c == 3) begin
        n_checks++;
        if (i_pmem_rdata !== pat) begin
          n_fail++; $display("FAIL i_read_rdata: got %h expected %h", i_pmem_rdata, pat);
        end
      end
      cyc();
    end
    clear_inputs();
    smp();
    n_checks++;
    if (ctl !== 4'b0000) begin
      n_fail++; $display("FAIL i_read_idle: got %b expected 0000", ctl);
    end
    cyc();
  endtask

  task automatic test_d_write();
    logic [127:0] wd;
    int pulses;
    wd = 128'h0123456789ABCDEF0123456789ABCDEF;
    pulses = 0;
    d_pmem_write = 1; d_pmem_address = 16'h8F0E; d_pmem_wdata = wd;
    for (int c = 0; c < 4; c++) begin
      l2_resp = (c == 3);
      smp();
      pulses += int'(d_pmem_resp);
      if (c >= 1) begin
        n_checks++;
        if ({l2_read, l2_write, i_pmem_resp} !== 3'b010 || l2_address !== 16'h8F00 || l2_wdata !== wd) begin
          n_fail++; $display("FAIL d_write_bus[%0d]: got rd%b wr%b ir%b addr %h wdata %h expected rd0 wr1 ir0 addr 8f00 wdata %h",
                             c, l2_read, l2_write, i_pmem_resp, l2_address, l2_wdata, wd);
        end
      end
      cyc();
    end
    clear_inputs();
    for (int c = 0; c < 2; c++) begin
      smp();
      pulses += int'(d_pmem_resp);
      cyc();
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++; $display("FAIL d_write_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    i_pmem_read = 1; i_pmem_address = 16'h4567;
    d_pmem_read = 1; d_pmem_address = 16'hBCDE;
    for (int k = 0; k < 12; k++) begin
      int  ph;
      bit  side_d;
      logic [3:0] exp_ctl;
      ph     = k % 3;
      side_d = ((k / 3) % 2) == 0;
      l2_resp  = (ph == 2);
      l2_rdata = {$urandom, $urandom, $urandom, $urandom};
      exp_ctl  = {ph != 0, 1'b0, ph == 2 && !side_d, ph == 2 && side_d};
      smp();
      n_checks++;
      if (ctl !== exp_ctl) begin
        n_fail++; $display("FAIL simul_ctl[%0d]: got %b expected %b", k, ctl, exp_ctl);
      end
      if (ph != 0) begin
        n_checks++;
        if (l2_address !== (side_d ? 16'hBCD0 : 16'h4560)) begin
          n_fail++; $display("FAIL simul_grant[%0d]: got addr %h expected %h", k, l2_address, side_d ? 16'hBCD0 : 16'h4560);
        end
      end
      cyc();
    end
    clear_inputs();
    smp();
    n_checks++;
    if (ctl !== 4'b0000) begin
      n_fail++; $display("FAIL simul_idle: got %b expected 0000", ctl);
    end
    cyc();
  endtask

  task automatic test_illegal_rw();
    d_pmem_read = 1; d_pmem_write = 1; d_pmem_address = 16'h2222;
    for (int c = 0; c < 4; c++) begin
      l2_resp = (c == 3);
      smp();
      if (c >= 1) begin
        n_checks++;
        if ({l2_read, l2_write} !== 2'b01) begin
          n_fail++; $display("FAIL illegal_rw[%0d]: got rd%b wr%b expected rd0 wr1", c, l2_read, l2_write);
        end
      end
      cyc();
    end
    clear_inputs();
    cyc();
  endtask

  task automatic test_spurious_resp();
    for (int c = 0; c < 3; c++) begin
      l2_resp = 1;
      smp();
      n_checks++;
      if (ctl !== 4'b0000) begin
        n_fail++; $display("FAIL spurious_resp[%0d]: got %b expected 0000", c, ctl);
      end
      cyc();
    end
    l2_resp = 0;
    i_pmem_read = 1; i_pmem_address = 16'h0ABC;
    smp();
    n_checks++;
    if (ctl !== 4'b0000) begin
      n_fail++; $display("FAIL spurious_still_idle: got %b expected 0000", ctl);
    end
    cyc();
    l2_resp = 1;
    smp();
    n_checks++;
    if (ctl !== 4'b1010 || l2_address !== 16'h0AB0) begin
      n_fail++; $display("FAIL spurious_then_grant: got %b addr %h expected 1010 addr 0ab0", ctl, l2_address);
    end
    cyc();
    clear_inputs();
    cyc();
  endtask

  task automatic test_reset_mid();
    for (int side = 0; side < 2; side++) begin
      if (side == 0) begin i_pmem_read = 1; i_pmem_address = 16'h1111; end
      else begin d_pmem_read = 1; d_pmem_address = 16'h3333; end
      cyc();
      smp();
      n_checks++;
      if (ctl !== 4'b1000) begin
        n_fail++; $display("FAIL reset_mid_serving[%0d]: got %b expected 1000", side, ctl);
      end
      reset = 1;
      cyc();
      reset = 0;
      clear_inputs();
      l2_resp = 1;
      smp();
      n_checks++;
      if (ctl !== 4'b0000) begin
        n_fail++; $display("FAIL reset_mid_late_resp[%0d]: got %b expected 0000", side, ctl);
      end
      cyc();
      l2_resp = 0;
      i_pmem_read = 1; i_pmem_address = 16'h5555;
      d_pmem_read = 1; d_pmem_address = 16'h6666;
      cyc();
      l2_resp = 1;
      smp();
      n_checks++;
      if (ctl !== 4'b1001 || l2_address !== 16'h6660) begin
        n_fail++; $display("FAIL reset_mid_regrant[%0d]: got %b addr %h expected 1001 addr 6660", side, ctl, l2_address);
      end
      cyc();
      clear_inputs();
      cyc();
    end
  endtask

  task automatic test_random();
    int   owner;   // -1 nobody, 0 I-cache, 1 D-cache
    bit   last;
    bit   ir, dr;
    logic [3:0]   e_ctl;
    logic [15:0]  e_addr;
    logic [127:0] e_wd;
    bit   chk_wd;
    do_reset();
    owner = -1;
    last  = 0;
    for (int n = 0; n < 400; n++) begin
      reset          = ($urandom_range(0, 49) == 0);
      i_pmem_read    = 1'($urandom_range(0, 1));
      i_pmem_address = 16'($urandom);
      d_pmem_read    = ($urandom_range(0, 2) == 0);
      d_pmem_write   = ($urandom_range(0, 3) == 0);
      d_pmem_address = 16'($urandom);
      d_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
      l2_rdata       = {$urandom, $urandom, $urandom, $urandom};
      l2_resp        = ($urandom_range(0, 2) == 0);
      smp();
      e_ctl = 4'b0000; e_addr = '0; e_wd = '0; chk_wd = 1;
      if (owner == 0) begin
        e_ctl  = {1'b1, 1'b0, l2_resp, 1'b0};
        e_addr = i_pmem_address & 16'hFFF0;
        chk_wd = 0;
      end else if (owner == 1) begin
        e_ctl  = {d_pmem_read && !d_pmem_write, d_pmem_write, 1'b0, l2_resp};
        e_addr = d_pmem_address & 16'hFFF0;
        e_wd   = d_pmem_wdata;
      end
      n_checks++;
      if (ctl !== e_ctl) begin
        n_fail++; $display("FAIL rand_ctl[%0d]: got %b expected %b", n, ctl, e_ctl);
      end
      n_checks++;
      if (l2_address !== e_addr) begin
        n_fail++; $display("FAIL rand_addr[%0d]: got %h expected %h", n, l2_address, e_addr);
      end
      if (chk_wd) begin
        n_checks++;
        if (l2_wdata !== e_wd) begin
          n_fail++; $display("FAIL rand_wdata[%0d]: got %h expected %h", n, l2_wdata, e_wd);
        end
      end
      n_checks++;
      if (i_pmem_rdata !== l2_rdata || d_pmem_rdata !== l2_rdata) begin
        n_fail++; $display("FAIL rand_rdata[%0d]: got i %h d %h expected %h", n, i_pmem_rdata, d_pmem_rdata, l2_rdata);
      end
      ir = i_pmem_read;
      dr = d_pmem_read || d_pmem_write;
      if (reset) begin
        owner = -1; last = 0;
      end else if (owner == -1) begin
        if (ir && dr)  owner = last ? 0 : 1;
        else if (ir)   owner = 0;
        else if (dr)   owner = 1;
        if (owner != -1) last = (owner == 1);
      end else if (l2_resp) begin
        owner = -1;
      end
      cyc();
    end
    reset = 0;
    clear_inputs();
    cyc();
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_i_read();
    test_d_write();
    test_simultaneous();
    test_illegal_rw();
    test_spurious_resp();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-port arbiter sharing the single L2 port between the L1 instruction cache (read-only) and the L1 data cache (read/write). Sits between the two L1 cache miss/writeback ports and the L2 cache. Serves one 128-bit line transaction at a time and forwards the L2 response only to the granted requester. Resolves simultaneous requests round-robin, so neither pipeline stage starves.

## Interface
- No parameters; widths are fixed by the LC-3b types: address 16 bits (`lc3b_word`), line 128 bits (`lc3b_l1_line` / `lc3b_l2_line`).
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- i_pmem_read  in  1  I-cache line read request, level, held until i_pmem_resp
- i_pmem_address  in  16  I-cache request address
- i_pmem_rdata  out  128  line returned to I-cache
- i_pmem_resp  out  1  one-cycle completion pulse to I-cache
- d_pmem_read  in  1  D-cache line read request, level
- d_pmem_write  in  1  D-cache line write (writeback) request, level
- d_pmem_address  in  16  D-cache request address
- d_pmem_wdata  in  128  D-cache writeback line
- d_pmem_rdata  out  128  line returned to D-cache
- d_pmem_resp  out  1  one-cycle completion pulse to D-cache
- l2_read  out  1  read request to L2
- l2_write  out  1  write request to L2
- l2_address  out  16  line-aligned L2 address
- l2_wdata  out  128  write line to L2
- l2_rdata  in  128  read line from L2
- l2_resp  in  1  one-cycle L2 completion pulse

## Operation
- States: IDLE, SERVE_I, SERVE_D. Register last_grant (0 = I, 1 = D).
- IDLE:
  - I-cache request only (i_pmem_read) → SERVE_I.
  - D-cache request only (d_pmem_read | d_pmem_write) → SERVE_D.
  - Both requesting → grant the side not equal to last_grant.
  - On each grant, last_grant updates to the granted side.
- SERVE_I: l2_read=1, l2_write=0, l2_address = {i_pmem_address[15:4], 4'b0}. On l2_resp: i_pmem_resp=1, i_pmem_rdata=l2_rdata (same cycle, combinational); next state IDLE.
- SERVE_D: l2_read = d_pmem_read & ~d_pmem_write; l2_write = d_pmem_write; l2_address = {d_pmem_address[15:4], 4'b0}; l2_wdata = d_pmem_wdata. On l2_resp: d_pmem_resp=1, d_pmem_rdata=l2_rdata; next state IDLE.
- Read and write asserted together by the D-cache is illegal; the write wins and no read is issued.
- The non-granted resp output stays 0 in every state. Both rdata outputs continuously mirror l2_rdata; only the resp pulse qualifies them.
- Address and wdata pass through combinationally. Requesters hold them stable until their resp.
- A requester dropping its request while granted is a protocol violation. The arbiter stays in its SERVE state until l2_resp regardless, and the L2 request signals follow the (now deasserted) inputs.
- l2_resp received in IDLE is ignored: no resp to either requester, no state change.

## Timing
- Reset (synchronous, when reset=1 at a rising edge) forces state=IDLE and last_grant=0. The first simultaneous request after reset therefore goes to the D-cache.
- Outputs are a combinational function of state and inputs. In IDLE: l2_read=0, l2_write=0, l2_address=0, l2_wdata=0, and i_pmem_resp=0, d_pmem_resp=0.
- Latency:
  - Request high at edge N while in IDLE → SERVE_x from N+1; the L2 request is visible in cycle N+1.
  - l2_resp in cycle M → requester resp in cycle M; back in IDLE at M+1.
  - Earliest next grant is at edge M+2. Each transaction costs exactly one IDLE bubble cycle.
- A requester whose request is still high in the IDLE cycle after its own resp is treated as a new request.
- Reset asserted mid-transaction:
  - Next edge returns to IDLE and drops the L2 request.
  - An l2_resp arriving after reset is ignored.
  - The L2 side is reset in the same cycle by system convention.
- The arbiter holds no data registers. Only state (2 bits) and last_grant (1 bit) are sequential.

## Test plan
- I-only read: i_pmem_read=1, address 0x1234; L2 returns resp after 3 cycles with rdata 0xAAAA…AA → l2_read high cycles 1-3, l2_address=0x1230, i_pmem_resp=1 in cycle 3 with i_pmem_rdata=0xAAAA…AA, d_pmem_resp never 1.
- D writeback: d_pmem_write=1, address 0x8F0E, wdata 0x0123…EF → l2_write=1, l2_read=0, l2_address=0x8F00, l2_wdata=0x0123…EF, d_pmem_resp pulses exactly once on l2_resp.
- Simultaneous requests from reset: both held high, L2 responds in 2 cycles each → grant order D, I, D, I with one IDLE cycle between transactions; both sides see a resp every 6 cycles.
- Illegal D read+write: d_pmem_read=d_pmem_write=1 → l2_write=1 and l2_read=0 throughout.
- Spurious l2_resp in IDLE with no requests → both resp outputs stay 0 and state stays IDLE.
- Reset mid-transaction: assert reset for 1 cycle while in SERVE_I before l2_resp → next cycle l2_read=0, and a later l2_resp produces no i_pmem_resp. The next simultaneous request is granted to the D-cache.
